seq_restoring_divider: RTL and testbench

//   Sequential restoring divider, N-bit by N-bit unsigned: computes q = x / y, r = x % y.

---
 rtl/seq_restoring_divider.sv | 127 ++++++++++++
 tb/tb_seq_restoring_divider.sv | 168 ++++++++++++++++
 2 files changed

// File: rtl/seq_restoring_divider.sv
// Sequential restoring divider, N-bit unsigned: q = x / y, r = x % y, one quotient bit per clock.
// Latency N cycles from the start edge (divide-by-zero resolves on the start edge); soc ignored while busy.
module seq_restoring_divider #(
  parameter int N = 8
) (
  input  logic         clock,
  input  logic         reset_,
  input  logic         soc,
  input  logic [N-1:0] x,
  input  logic [N-1:0] y,
  output logic         eoc,
  output logic [N-1:0] q,
  output logic [N-1:0] r,
  output logic         dz
);

  localparam int CW = $clog2(N + 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_STEP = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t        state_q, state_d;
  logic [N-1:0]  x_q, x_d;
  logic [N-1:0]  y_q, y_d;
  logic [N-1:0]  rem_q, rem_d;
  logic [N-1:0]  quo_q, quo_d;
  logic [N-1:0]  q_q, q_d;
  logic [N-1:0]  r_q, r_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          dz_q, dz_d;

  logic [N:0]    p;
  logic [N:0]    diff;
  logic          ge;
  logic [N-1:0]  rem_step;
  logic [N-1:0]  quo_step;

  // Shared step datapath: the top bit of the (N+1)-bit difference is the borrow.
  always_comb begin
    p        = {rem_q, x_q[N-1]};
    diff     = p - {1'b0, y_q};
    ge       = ~diff[N];
    rem_step = ge ? diff[N-1:0] : p[N-1:0];
    quo_step = {quo_q[N-2:0], ge};
  end

  always_comb begin
    state_d = state_q;
    x_d     = x_q;
    y_d     = y_q;
    rem_d   = rem_q;
    quo_d   = quo_q;
    cnt_d   = cnt_q;
    q_d     = q_q;
    r_d     = r_q;
    dz_d    = dz_q;
    case (state_q)
      S_IDLE: begin
        if (soc) begin
          if (y != '0) begin
            x_d     = x;
            y_d     = y;
            rem_d   = '0;
            quo_d   = '0;
            cnt_d   = CW'(N);
            state_d = S_STEP;
          end else begin
            q_d     = '1;
            r_d     = x;
            dz_d    = 1'b1;
            state_d = S_DONE;
          end
        end
      end
      S_STEP: begin
        rem_d = rem_step;
        quo_d = quo_step;
        x_d   = x_q << 1;
        cnt_d = cnt_q - CW'(1);
        if (cnt_q == CW'(1)) begin
          q_d     = quo_step;
          r_d     = rem_step;
          dz_d    = 1'b0;
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        // Wait for soc to drop so a held start cannot retrigger.
        if (!soc) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset_) begin
    if (!reset_) begin
      state_q <= S_IDLE;
      x_q     <= '0;
      y_q     <= '0;
      rem_q   <= '0;
      quo_q   <= '0;
      cnt_q   <= '0;
      q_q     <= '0;
      r_q     <= '0;
      dz_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      x_q     <= x_d;
      y_q     <= y_d;
      rem_q   <= rem_d;
      quo_q   <= quo_d;
      cnt_q   <= cnt_d;
      q_q     <= q_d;
      r_q     <= r_d;
      dz_q    <= dz_d;
    end
  end

  assign eoc = (state_q != S_STEP);
  assign q   = q_q;
  assign r   = r_q;
  assign dz  = dz_q;

endmodule

// File: tb/tb_seq_restoring_divider.sv
// Directed and randomized bench for seq_restoring_divider against a plain-arithmetic reference.
module tb_seq_restoring_divider;

  localparam int N = 8;
  localparam int MAXV = (1 << N) - 1;

  logic         clock;
  logic         reset_;
  logic         soc;
  logic [N-1:0] x;
  logic [N-1:0] y;
  logic         eoc;
  logic [N-1:0] q;
  logic [N-1:0] r;
  logic         dz;

  int errors = 0;
  int checks = 0;

  seq_restoring_divider #(.N(N)) dut (
    .clock  (clock),
    .reset_ (reset_),
    .soc    (soc),
    .x      (x),
    .y      (y),
    .eoc    (eoc),
    .q      (q),
    .r      (r),
    .dz     (dz)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Runs one division from IDLE and checks latency, stability while busy and the result.
  task automatic do_op(input int xi, input int yi, input string tag);
    int n;
    int q_prev, r_prev;
    bit stable;
    int q_exp, r_exp, dz_exp, lat_exp;
    if (yi == 0) begin
      q_exp = MAXV; r_exp = xi; dz_exp = 1; lat_exp = 0;
    end else begin
      q_exp = xi / yi; r_exp = xi % yi; dz_exp = 0; lat_exp = N;
    end
    soc = 1'b0;
    @(negedge clock);
    q_prev = int'(q);
    r_prev = int'(r);
    soc = 1'b1;
    x   = N'(xi);
    y   = N'(yi);
    @(negedge clock);
    soc = 1'b0;
    x   = N'($urandom);
    y   = N'($urandom);
    n = 0;
    stable = 1'b1;
    while (eoc !== 1'b1 && n < 4 * N) begin
      if (int'(q) != q_prev || int'(r) != r_prev) stable = 1'b0;
      @(negedge clock);
      n++;
      x = N'($urandom);
    end
    chk({tag, ".latency"}, n, lat_exp);
    if (yi != 0) chk({tag, ".stable_busy"}, int'(stable), 1);
    chk({tag, ".q"}, int'(q), q_exp);
    chk({tag, ".r"}, int'(r), r_exp);
    chk({tag, ".dz"}, int'(dz), dz_exp);
    if (yi != 0)
      chk({tag, ".identity"}, int'((int'(q) * yi + int'(r) == xi) && (int'(r) < yi)), 1);
  endtask

  initial begin
    int n;
    int xr, yr;
    reset_ = 1'b0;
    soc    = 1'b0;
    x      = '0;
    y      = '0;
    #2;
    chk("reset.eoc", int'(eoc), 1);
    chk("reset.q",   int'(q),   0);
    chk("reset.r",   int'(r),   0);
    chk("reset.dz",  int'(dz),  0);
    @(negedge clock);
    @(negedge clock);
    reset_ = 1'b1;
    @(negedge clock);

    do_op(200, 7, "t1_200_7");
    do_op(255, 1, "t2_255_1");
    do_op(5, 9, "t2_5_9");
    do_op(0, 3, "t2_0_3");
    do_op(17, 0, "t3_17_0");
    do_op(10, 3, "t3_10_3");
    do_op(MAXV, MAXV, "bnd_max_max");
    do_op(77, 77, "bnd_x_eq_y");
    do_op(0, 0, "bnd_0_0");

    // Asynchronous reset during the fourth step cycle of 200/7.
    soc = 1'b0;
    @(negedge clock);
    soc = 1'b1; x = 8'd200; y = 8'd7;
    @(negedge clock);
    soc = 1'b0;
    chk("t4.busy", int'(eoc), 0);
    repeat (3) @(negedge clock);
    reset_ = 1'b0;
    #1;
    chk("t4.rst_eoc", int'(eoc), 1);
    chk("t4.rst_q",   int'(q),   0);
    chk("t4.rst_r",   int'(r),   0);
    chk("t4.rst_dz",  int'(dz),  0);
    @(negedge clock);
    reset_ = 1'b1;
    do_op(100, 9, "t4_100_9");

    // soc held high through completion: the unit must park in DONE.
    soc = 1'b0;
    @(negedge clock);
    soc = 1'b1; x = 8'd150; y = 8'd11;
    @(negedge clock);
    x = 8'd3; y = 8'd2;
    n = 0;
    while (eoc !== 1'b1 && n < 4 * N) begin
      @(negedge clock);
      n++;
    end
    chk("t5.latency", n, N);
    chk("t5.q", int'(q), 13);
    chk("t5.r", int'(r), 7);
    for (int i = 0; i < 5; i++) begin
      x = N'($urandom); y = N'($urandom_range(MAXV, 1));
      @(negedge clock);
      chk("t5.hold_eoc", int'(eoc), 1);
      chk("t5.hold_q", int'(q), 13);
    end
    soc = 1'b0;
    @(negedge clock);

    for (int i = 0; i < 1000; i++) begin
      xr = int'($urandom_range(MAXV, 0));
      yr = int'($urandom_range(MAXV, 1));
      do_op(xr, yr, "rand");
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2000000;
    errors++;
    $display("FAIL watchdog: simulation did not finish, observed=timeout expected=finish");
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $fatal(1, "watchdog");
  end

endmodule
